// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and frame length.
// Both the transmitter and the receiver import this so they agree on the line format.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 50;

  // Number of bit periods in one frame: start + data + stop.
  function automatic int frame_bits(input int data_bits, input int stop_bits);
    return 1 + data_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// A synchronous clear restarts the period, e.g. on a frame accept or a start-edge detect.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: takes one word per valid/ready handshake and serialises it
// as start(0), data LSB first, stop(1) bits on a registered, idle-high line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [1:0]           state_value,
  output logic [3:0]           bit_cnt_value
);

  uart_state_e          state, state_next;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 accept;
  logic                 last_data;
  logic                 last_stop;

  assign accept    = (state == UART_IDLE) && tx_valid;
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  // bit_cnt doubles as the stop-bit counter; it is hidden from bit_cnt_value in STOP.
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .en   (state != UART_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UART_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      UART_IDLE:  if (tx_valid)           state_next = UART_START;
      UART_START: if (tick)               state_next = UART_DATA;
      UART_DATA:  if (tick && last_data)  state_next = UART_STOP;
      UART_STOP:  if (tick && last_stop)  state_next = UART_IDLE;
      default:                            state_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx_ready      = (state == UART_IDLE);
    busy          = (state != UART_IDLE);
    state_value   = state;
    bit_cnt_value = (state == UART_DATA) ? bit_cnt : 4'd0;
  end

  // NOTE: the shift register is reset too; it is a handful of flops, so a clean start costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      uart_tx <= 1'b1;
    end else begin
      unique case (state)
        UART_IDLE: begin
          if (accept) begin
            shift   <= tx_data;
            bit_cnt <= '0;
            uart_tx <= 1'b0;
          end
        end
        UART_START: begin
          if (tick) begin
            uart_tx <= shift[0];
            bit_cnt <= '0;
          end
        end
        UART_DATA: begin
          if (tick) begin
            if (!last_data) begin
              shift   <= shift >> 1;
              uart_tx <= shift[1];
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              uart_tx <= 1'b1;
              bit_cnt <= '0;
            end
          end
        end
        UART_STOP: begin
          uart_tx <= 1'b1;
          if (tick) bit_cnt <= last_stop ? 4'd0 : bit_cnt + 4'd1;
        end
        default: begin
          uart_tx <= 1'b1;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a line-sampling receiver model pops expected
// words from a scoreboard filled at each accept edge; a second instance covers 7 data / 2 stop bits.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int  CPB    = 50;
  localparam time PERIOD = 20;
  localparam time BIT_T  = CPB * PERIOD;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] data_a;
  logic       valid_a, ready_a, tx_a, busy_a;
  logic [1:0] st_a;
  logic [3:0] bc_a;

  logic [6:0] data_b;
  logic       valid_b, ready_b, tx_b, busy_b;
  logic [1:0] st_b;
  logic [3:0] bc_b;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  always #(PERIOD / 2) clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .uart_tx(tx_a), .busy(busy_a), .state_value(st_a), .bit_cnt_value(bc_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .uart_tx(tx_b), .busy(busy_b), .state_value(st_b), .bit_cnt_value(bc_b)
  );

  function automatic logic line_of(input int w);   return (w != 0) ? tx_b    : tx_a;    endfunction
  function automatic logic ready_of(input int w);  return (w != 0) ? ready_b : ready_a; endfunction
  function automatic logic valid_of(input int w);  return (w != 0) ? valid_b : valid_a; endfunction
  function automatic logic busy_of(input int w);   return (w != 0) ? busy_b  : busy_a;  endfunction
  function automatic logic [1:0] st_of(input int w); return (w != 0) ? st_b  : st_a;    endfunction
  function automatic logic [3:0] bc_of(input int w); return (w != 0) ? bc_b  : bc_a;    endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Waits (bounded) for a handshake, returns the accept edge time and logs the word.
  task automatic wait_accept(input int w, output time t);
    bit hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      if (ready_of(w) && valid_of(w)) hit = 1'b1;
      else @(negedge clk);
    end
    check("accept_seen", 32'(hit), 32'd1);
    if (!hit) begin
      t = $time;
      return;
    end
    @(posedge clk);
    t = $time;
    if (w == 0) exp_q.push_back(data_a);
    else        exp_q.push_back({1'b0, data_b});
    #1;
    check("accept_line_low", 32'(line_of(w)), 32'd0);
    check("accept_busy",     32'(busy_of(w)), 32'd1);
    check("accept_state",    32'(st_of(w)),   32'd1);
    check("accept_ready",    32'(ready_of(w)), 32'd0);
  endtask

  // Samples one frame at mid-bit points relative to the accept edge t0.
  task automatic recv_frame(input int w, input time t0);
    int         dbits = (w != 0) ? 7 : 8;
    int         sbits = (w != 0) ? 2 : 1;
    int         nbits = frame_bits(dbits, sbits);
    logic [7:0] got   = '0;
    logic [7:0] exp;
    check("sb_not_empty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    exp = exp_q.pop_front();
    wait_until(t0 + BIT_T / 2 + 5);
    check("start_mid_line",  32'(line_of(w)), 32'd0);
    check("start_mid_state", 32'(st_of(w)),   32'd1);
    wait_until(t0 + BIT_T - 5);
    check("start_end_line",  32'(line_of(w)), 32'd0);
    wait_until(t0 + BIT_T + 5);
    check("bit0_begin_line", 32'(line_of(w)), 32'(exp[0]));
    for (int i = 0; i < dbits; i++) begin
      wait_until(t0 + (1 + i) * BIT_T + BIT_T / 2 + 5);
      got[i] = line_of(w);
      check("data_state",   32'(st_of(w)), 32'd2);
      check("data_bit_cnt", 32'(bc_of(w)), 32'(i));
    end
    for (int s = 0; s < sbits; s++) begin
      wait_until(t0 + (1 + dbits + s) * BIT_T + BIT_T / 2 + 5);
      check("stop_line",    32'(line_of(w)), 32'd1);
      check("stop_state",   32'(st_of(w)),   32'd3);
      check("stop_bit_cnt", 32'(bc_of(w)),   32'd0);
    end
    check("rx_byte", 32'(got), 32'(exp));
    wait_until(t0 + nbits * BIT_T - 5);
    check("frame_end_ready_low", 32'(ready_of(w)), 32'd0);
    check("frame_end_busy",      32'(busy_of(w)),  32'd1);
    wait_until(t0 + nbits * BIT_T + 5);
    check("idle_ready",  32'(ready_of(w)), 32'd1);
    check("idle_state",  32'(st_of(w)),    32'd0);
    check("idle_line",   32'(line_of(w)),  32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[4];
    time        t, t_prev;

    seq = '{8'h35, 8'hA5, 8'h00, 8'hFF};
    rst_n   = 1'b1;
    data_a  = '0;
    valid_a = 1'b0;
    data_b  = '0;
    valid_b = 1'b0;

    // Reset values
    #5 rst_n = 1'b0;
    #1;
    check("rst_line",  32'(tx_a),    32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_state", 32'(st_a),    32'd0);
    check("rst_b_line", 32'(tx_b),   32'd1);
    #30 rst_n = 1'b1;

    // 1: single-cycle valid pulse with 0x35
    @(negedge clk);
    data_a  = 8'h35;
    valid_a = 1'b1;
    wait_accept(0, t);
    valid_a = 1'b0;
    recv_frame(0, t);

    // 2: back-to-back words with valid held high
    @(negedge clk);
    data_a  = seq[0];
    valid_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(0, t);
      if (k > 0) check("b2b_spacing", 32'((t - t_prev) / PERIOD), 32'd501);
      t_prev = t;
      if (k < 3) data_a = seq[k + 1];
      else       valid_a = 1'b0;
      recv_frame(0, t);
    end

    // 3: data changes after accept must not disturb the frame in flight
    @(negedge clk);
    data_a  = 8'h35;
    valid_a = 1'b1;
    wait_accept(0, t);
    t_prev = t;
    @(posedge clk);
    #1 data_a = 8'hCA;
    recv_frame(0, t);
    wait_accept(0, t);
    check("pending_spacing", 32'((t - t_prev) / PERIOD), 32'd501);
    valid_a = 1'b0;
    recv_frame(0, t);

    // valid raised and dropped while busy: nothing extra is sent
    @(negedge clk);
    data_a  = 8'h12;
    valid_a = 1'b1;
    wait_accept(0, t);
    valid_a = 1'b0;
    #40 data_a = 8'h99;
    valid_a = 1'b1;
    #360 valid_a = 1'b0;
    recv_frame(0, t);
    #(60 * PERIOD);
    check("no_spurious_state", 32'(st_a), 32'd0);
    check("no_spurious_line",  32'(tx_a), 32'd1);
    check("sb_drained",        32'(exp_q.size()), 32'd0);

    // 4: asynchronous reset during data bit 3, then a clean 0x55 frame
    @(negedge clk);
    data_a  = 8'hE7;
    valid_a = 1'b1;
    wait_accept(0, t);
    valid_a = 1'b0;
    wait_until(t + 4 * BIT_T + BIT_T / 2 + 5);
    check("pre_rst_bit_cnt", 32'(bc_a), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_line",  32'(tx_a),    32'd1);
    check("async_rst_state", 32'(st_a),    32'd0);
    check("async_rst_busy",  32'(busy_a),  32'd0);
    check("async_rst_ready", 32'(ready_a), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    #30 rst_n = 1'b1;
    @(negedge clk);
    data_a  = 8'h55;
    valid_a = 1'b1;
    wait_accept(0, t);
    valid_a = 1'b0;
    recv_frame(0, t);

    // 5: 7 data bits, 2 stop bits, 0x7F twice back-to-back
    @(negedge clk);
    data_b  = 7'h7F;
    valid_b = 1'b1;
    wait_accept(1, t);
    t_prev = t;
    recv_frame(1, t);
    wait_accept(1, t);
    check("b_spacing", 32'((t - t_prev) / PERIOD), 32'd501);
    valid_b = 1'b0;
    recv_frame(1, t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
